// File: rtl/sipo_receiver_if.sv
// Serial-link receive bundle: serial line and frame enable in,
// parallel word with valid/ack handshake and status flags out.
interface sipo_receiver_if #(
  parameter int WIDTH = 8
);
  logic             s;
  logic             en;
  logic             ack;
  logic [WIDTH-1:0] p;
  logic             valid;
  logic             overrun;
  logic             ferr;
  logic             busy;

  modport master (
    output s, en, ack,
    input  p, valid, overrun, ferr, busy
  );

  modport slave (
    input  s, en, ack,
    output p, valid, overrun, ferr, busy
  );
endinterface

// File: rtl/sipo_receiver.sv
// MSB-first serial-to-parallel receiver with valid/ack handshake,
// sticky overrun and one-cycle truncated-frame pulse.
module sipo_receiver #(
  parameter int WIDTH = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  sipo_receiver_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  logic [WIDTH-1:0] r_sh, w_sh_n;
  logic [CW-1:0]    r_cnt, w_cnt_n;
  logic [WIDTH-1:0] r_p, w_p_n;
  logic             r_valid, w_valid_n;
  logic             r_ovr, w_ovr_n;
  logic             r_ferr, w_ferr_n;
  logic             w_done;
  logic [WIDTH-1:0] w_word;
  state_t           w_state;

  assign w_state = (r_cnt == '0) ? IDLE : SHIFT;
  assign w_word  = {r_sh[WIDTH-2:0], bus.s};
  assign w_done  = bus.en && (r_cnt == CW'(WIDTH-1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sh    <= '0;
      r_cnt   <= '0;
      r_p     <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_sh    <= w_sh_n;
      r_cnt   <= w_cnt_n;
      r_p     <= w_p_n;
      r_valid <= w_valid_n;
      r_ovr   <= w_ovr_n;
      r_ferr  <= w_ferr_n;
    end
  end

  always_comb begin
    w_sh_n    = r_sh;
    w_cnt_n   = r_cnt;
    w_p_n     = r_p;
    w_valid_n = r_valid;
    w_ovr_n   = r_ovr;
    w_ferr_n  = 1'b0;

    if (bus.en) begin
      if (w_done) begin
        w_sh_n  = '0;
        w_cnt_n = '0;
      end else begin
        w_sh_n  = w_word;
        w_cnt_n = r_cnt + CW'(1);
      end
    end else if (w_state == SHIFT) begin
      // partial word dropped; p/valid untouched
      w_sh_n   = '0;
      w_cnt_n  = '0;
      w_ferr_n = 1'b1;
    end

    if (w_done) begin
      w_p_n     = w_word;
      w_valid_n = 1'b1;
      if (r_valid && !bus.ack)
        w_ovr_n = 1'b1;
    end else if (bus.ack) begin
      w_valid_n = 1'b0;
      w_ovr_n   = 1'b0;
    end
  end

  assign bus.p       = r_p;
  assign bus.valid   = r_valid;
  assign bus.overrun = r_ovr;
  assign bus.ferr    = r_ferr;
  assign bus.busy    = (w_state == SHIFT);
endmodule

// File: tb/tb_sipo_receiver.sv
// Directed bench for sipo_receiver: reset, single word, streaming,
// overrun, simultaneous ack/completion and truncated frames.
module tb_sipo_receiver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  sipo_receiver_if #(.WIDTH(8)) bus ();

  sipo_receiver #(.WIDTH(8)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic a);
    bus.en  = 1'b1;
    bus.s   = b;
    bus.ack = a;
    tick();
    bus.en  = 1'b0;
    bus.ack = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input logic ack_last);
    for (int i = 7; i >= 0; i--)
      send_bit(w[i], ack_last && (i == 0));
  endtask

  task automatic do_ack();
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    if (bus.p !== 8'h00) begin
      $display("FAIL reset_p got %h exp 00", bus.p); n_bad++;
    end
    n_cmp++;
    if (bus.valid !== 1'b0 || bus.busy !== 1'b0) begin
      $display("FAIL reset_vb got %b%b exp 00", bus.valid, bus.busy); n_bad++;
    end
    n_cmp++;
    send_word(8'h5A, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    if (bus.busy !== 1'b1) begin
      $display("FAIL busy_mid got %b exp 1", bus.busy); n_bad++;
    end
    n_cmp++;
    bus.en = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    bus.en = 1'b0;
    if ({bus.p, bus.valid, bus.overrun, bus.ferr, bus.busy} !== 12'h000) begin
      $display("FAIL reset_mid got p=%h v=%b o=%b f=%b b=%b exp all 0",
               bus.p, bus.valid, bus.overrun, bus.ferr, bus.busy);
      n_bad++;
    end
    n_cmp++;
    send_word(8'h96, 1'b0);
    if (bus.p !== 8'h96 || bus.valid !== 1'b1) begin
      $display("FAIL reset_fresh got p=%h v=%b exp 96/1", bus.p, bus.valid);
      n_bad++;
    end
    n_cmp++;
    do_ack();
  endtask

  task automatic test_single();
    send_word(8'hA5, 1'b0);
    if (bus.p !== 8'hA5 || bus.valid !== 1'b1 || bus.busy !== 1'b0) begin
      $display("FAIL single got p=%h v=%b b=%b exp a5/1/0",
               bus.p, bus.valid, bus.busy);
      n_bad++;
    end
    n_cmp++;
    do_ack();
    if (bus.p !== 8'hA5 || bus.valid !== 1'b0) begin
      $display("FAIL single_ack got p=%h v=%b exp a5/0", bus.p, bus.valid);
      n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] bits;
    bits = 16'h3CC3;
    for (int i = 0; i < 16; i++) begin
      send_bit(bits[15-i], i == 8);
      if (i == 7) begin
        if (bus.p !== 8'h3C || bus.valid !== 1'b1) begin
          $display("FAIL b2b_first got p=%h v=%b exp 3c/1", bus.p, bus.valid);
          n_bad++;
        end
        n_cmp++;
      end
      if (i == 8) begin
        if (bus.valid !== 1'b0 || bus.busy !== 1'b1) begin
          $display("FAIL b2b_ack got v=%b b=%b exp 0/1", bus.valid, bus.busy);
          n_bad++;
        end
        n_cmp++;
      end
    end
    if (bus.p !== 8'hC3 || bus.valid !== 1'b1 || bus.overrun !== 1'b0) begin
      $display("FAIL b2b_second got p=%h v=%b o=%b exp c3/1/0",
               bus.p, bus.valid, bus.overrun);
      n_bad++;
    end
    n_cmp++;
    do_ack();
  endtask

  task automatic test_overrun();
    send_word(8'h12, 1'b0);
    send_word(8'h34, 1'b0);
    if (bus.p !== 8'h34 || bus.valid !== 1'b1 || bus.overrun !== 1'b1) begin
      $display("FAIL ovr_set got p=%h v=%b o=%b exp 34/1/1",
               bus.p, bus.valid, bus.overrun);
      n_bad++;
    end
    n_cmp++;
    tick();
    if (bus.overrun !== 1'b1) begin
      $display("FAIL ovr_sticky got %b exp 1", bus.overrun); n_bad++;
    end
    n_cmp++;
    do_ack();
    if (bus.valid !== 1'b0 || bus.overrun !== 1'b0) begin
      $display("FAIL ovr_clear got v=%b o=%b exp 0/0", bus.valid, bus.overrun);
      n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_simul_ack();
    send_word(8'h12, 1'b0);
    send_word(8'h34, 1'b1);
    if (bus.p !== 8'h34 || bus.valid !== 1'b1 || bus.overrun !== 1'b0) begin
      $display("FAIL simul got p=%h v=%b o=%b exp 34/1/0",
               bus.p, bus.valid, bus.overrun);
      n_bad++;
    end
    n_cmp++;
    do_ack();
  endtask

  task automatic test_truncated();
    tick();
    if (bus.ferr !== 1'b0) begin
      $display("FAIL idle_noferr got %b exp 0", bus.ferr); n_bad++;
    end
    n_cmp++;
    for (int i = 0; i < 5; i++)
      send_bit(1'b1, 1'b0);
    tick();
    if (bus.ferr !== 1'b1 || bus.busy !== 1'b0) begin
      $display("FAIL trunc_ferr got f=%b b=%b exp 1/0", bus.ferr, bus.busy);
      n_bad++;
    end
    n_cmp++;
    if (bus.p !== 8'h34 || bus.valid !== 1'b0) begin
      $display("FAIL trunc_hold got p=%h v=%b exp 34/0", bus.p, bus.valid);
      n_bad++;
    end
    n_cmp++;
    tick();
    if (bus.ferr !== 1'b0) begin
      $display("FAIL trunc_pulse got %b exp 0", bus.ferr); n_bad++;
    end
    n_cmp++;
    send_word(8'hFF, 1'b0);
    if (bus.p !== 8'hFF || bus.valid !== 1'b1) begin
      $display("FAIL trunc_next got p=%h v=%b exp ff/1", bus.p, bus.valid);
      n_bad++;
    end
    n_cmp++;
  endtask

  initial begin
    bus.s   = 1'b0;
    bus.en  = 1'b0;
    bus.ack = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_simul_ack();
    test_truncated();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sipo_receiver.md
# sipo_receiver

Serial-in, parallel-out deserializer: the receive end of the team's 8-bit MSB-first serial link. It samples one bit per clock while a frame-enable is high, assembles WIDTH-bit words and presents each one on a parallel bus with a valid/ack handshake. It also flags overruns and truncated frames. It sits between the serial line driven by the transmit-side shifter and the parallel consumer logic.

## Interface
- WIDTH, 8, word width in bits; must be ≥ 2. The bit counter is $clog2(WIDTH) bits wide.
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- s  input  1  serial data in, MSB first.
- en  input  1  frame enable; s is sampled on every rising edge where en=1.
- ack  input  1  consumer acknowledge; clears valid.
- p  output  WIDTH  last completed word.
- valid  output  1  p holds an unacknowledged word.
- overrun  output  1  sticky: a word completed while the previous one was still unacknowledged.
- ferr  output  1  one-cycle pulse: en fell with a partial word in progress.
- busy  output  1  a partial word is being assembled (bit count ≠ 0).

## Operation
- **Reset (rst=1 at an edge):** overrides everything. Forces sh=0, cnt=0, p=0, valid=0, overrun=0, ferr=0. busy is therefore 0.
- **State machine** (implicit in cnt): IDLE when cnt=0; SHIFT when cnt is 1..WIDTH-1.
- **Sampling (edge with en=1):**
  - sh ← {sh[WIDTH-2:0], s}.
  - cnt ← cnt+1, wrapping to 0 after the WIDTH-th bit.
- **Word completion** (en=1 and cnt=WIDTH-1 at the edge):
  - p ← {sh[WIDTH-2:0], s}; valid ← 1; cnt ← 0.
  - sh is cleared to 0 on the same edge.
- **Streaming:** if en stays high, the next edge samples the MSB of the following word, with no gap cycle.
- **en low with cnt=0:** the block holds. No ferr.
- **en low with cnt≠0 (truncated frame):**
  - On that edge: cnt ← 0, sh ← 0, ferr=1 for exactly one cycle.
  - The partial word is discarded; p and valid are unchanged.
- **Handshake:**
  - valid stays high until an edge with ack=1 and no simultaneous completion; then valid ← 0.
  - ack while valid=0 is ignored.
- **Completion while valid=1:**
  - With ack=0 on that edge: p is overwritten with the new word, valid stays 1, overrun ← 1.
  - With ack=1 on that edge: the old word counts as consumed. p takes the new word, valid stays 1, overrun is not set.
- **Clearing overrun:** it stays set until rst, or an edge with ack=1 and no completion.
- **busy:** combinational, equal to (cnt≠0).

## Timing
- **Latency:** p and valid update on the same edge that samples the word's LSB. They are visible in the cycle after the WIDTH-th sampling edge.
- **Throughput:** one word per WIDTH cycles under continuous en.
- **ferr:** asserted in the cycle after the edge where en was sampled low with cnt≠0. Deasserted on the following edge.
- **Outputs:** p, valid, overrun and ferr are registered. busy is decoded from the registered cnt.
- **Sampling point:** s and en are sampled only on rising edges. The serial source must drive s stable around the edge where en=1.

## Test plan
- **Reset:** assert rst for 2 cycles mid-word (after 3 bits) -> p=0x00, valid=0, overrun=0, ferr=0, busy=0. The next 8 bits with en=1 form a fresh word.
- **Single word:** en=1 for 8 cycles, s=1,0,1,0,0,1,0,1 -> after the 8th edge p=0xA5, valid=1, busy=0. Then ack=1 for one cycle -> valid=0, p stays 0xA5.
- **Back-to-back streaming:** en=1 for 16 cycles with bits of 0x3C then 0xC3, ack pulsed on the 9th edge -> p=0x3C after edge 8, p=0xC3 after edge 16, overrun=0.
- **Overrun:** two consecutive words 0x12, 0x34 with no ack -> after edge 16 p=0x34, valid=1, overrun=1. Then one ack -> valid=0, overrun=0.
- **Simultaneous ack/completion:** ack=1 on exactly the edge completing the second word 0x34 -> p=0x34, valid=1, overrun=0.
- **Truncated frame:** en=1 for 5 bits, then en=0 -> ferr high for exactly one cycle, busy=0, p/valid unchanged. The next full 8-bit frame 0xFF gives p=0xFF.
